// File: rtl/md_pkg.sv
// Shared encodings, state type and default latencies for the
// multiply/divide scheduler.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// Divider present only when MD_SCHED_DIV_EN is defined.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
`ifdef MD_SCHED_DIV_EN
    logic signed [31:0] sq;
    logic signed [31:0] sr;
`endif

    assign sa = {{32{a[31]}}, a};
    assign sb = {{32{b[31]}}, b};
    assign ua = {32'd0, a};
    assign ub = {32'd0, b};

    always_comb begin
        res      = 64'd0;
        div_zero = 1'b0;
`ifdef MD_SCHED_DIV_EN
        sq       = 32'sd0;
        sr       = 32'sd0;
`endif
        unique case (op)
            MD_MULT:  res = sa * sb;
            MD_MULTU: res = ua * ub;
`ifdef MD_SCHED_DIV_EN
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else begin
                    // Signed / and % truncate toward zero, remainder
                    // follows the dividend's sign.
                    sq  = $signed(a) / $signed(b);
                    sr  = $signed(a) % $signed(b);
                    res = {sr, sq};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else begin
                    res = {a % b, a / b};
                end
            end
`endif
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency HI/LO update, Busy and ID stall.
// Optional divider: define MD_SCHED_DIV_EN.
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_md_use,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        D_stall
);

    localparam int MAX_C = md_max(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W = $clog2(MAX_C + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_p_q, hi_p_d;
    logic [31:0]      lo_p_q, lo_p_d;
    logic             dz_q, dz_d;

    logic [63:0]      res;
    logic             div_zero;
    logic             is_mul;
    logic             is_div;

    md_arith u_arith (
        .op       (op),
        .a        (A),
        .b        (B),
        .res      (res),
        .div_zero (div_zero)
    );

    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_SCHED_DIV_EN
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
`else
    assign is_div = 1'b0;
`endif

    assign Start   = start && (state_q == S_IDLE) && (is_mul || is_div);
    assign Busy    = (state_q == S_RUN);
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign D_stall = D_md_use && (Busy || Start);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    hi_p_d  = res[63:32];
                    lo_p_d  = res[31:0];
                    dz_d    = div_zero;
                    state_d = S_RUN;
`ifdef MD_SCHED_DIV_EN
                    cnt_d = is_div ? CNT_W'(DIV_CYCLES)
                                   : CNT_W'(MULT_CYCLES);
`else
                    cnt_d = CNT_W'(MULT_CYCLES);
`endif
                end else if (start && op == MD_MTHI) begin
                    hi_d = A;
                end else if (start && op == MD_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // A zero divisor burns the full latency but commits nothing.
                    if (!dz_q) begin
                        hi_d = hi_p_q;
                        lo_d = lo_p_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_p_q  <= '0;
            lo_p_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
            dz_q    <= dz_d;
        end
    end

endmodule
